// File: rtl/io_bank_arbiter.sv
// Round-robin arbiter that hands a shared user IO bank to one requester at a time.
// Every change of owner passes through one turnaround cycle with all pads released.
module io_bank_arbiter #(
    parameter int N_REQ    = 2,
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] req_out_i,
    input  logic [N_REQ*WIDTH-1:0] req_oeb_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [WIDTH-1:0]       io_out,
    output logic [WIDTH-1:0]       io_oeb,
    output logic                   busy_o,
    output logic                   preempt_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [7:0]      cnt;

    logic [IW-1:0]   win;
    logic [IW-1:0]   win_next;
    logic            found;
    logic            others;
    logic            timeout;
    logic [N_REQ-1:0] win_onehot;
    int              idx;

    // Search from ptr upward, wrapping, and take the first active request.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        win_next   = IW'((int'(win) + 1) % N_REQ);
        win_onehot = '0;
        win_onehot[win] = 1'b1;
    end

    assign others  = |(req_i & ~gnt_o);
    assign timeout = (MAX_HOLD != 0) && (cnt == 8'(MAX_HOLD)) && others;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            gnt_o     <= '0;
            busy_o    <= 1'b0;
            preempt_o <= 1'b0;
            io_out    <= '0;
            io_oeb    <= '1;
        end else begin
            preempt_o <= 1'b0;
            unique case (state)
                IDLE, TURN: begin
                    io_out <= '0;
                    io_oeb <= '1;
                    cnt    <= '0;
                    if (found) begin
                        state  <= GRANT;
                        owner  <= win;
                        ptr    <= win_next;
                        gnt_o  <= win_onehot;
                        busy_o <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        gnt_o  <= '0;
                        busy_o <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req_i[owner] || timeout) begin
                        // A plain release wins over a coincident timeout.
                        preempt_o <= req_i[owner];
                        state     <= TURN;
                        gnt_o     <= '0;
                        busy_o    <= 1'b0;
                        io_out    <= '0;
                        io_oeb    <= '1;
                    end else begin
                        io_out <= req_out_i[owner*WIDTH +: WIDTH];
                        io_oeb <= req_oeb_i[owner*WIDTH +: WIDTH];
                        if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                    io_out <= '0;
                    io_oeb <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bank_arbiter.sv
// Directed bench for io_bank_arbiter with N_REQ=2, WIDTH=16, MAX_HOLD=4.
module tb_io_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] req_out;
    logic [31:0] req_oeb;
    logic [1:0]  gnt;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic        busy;
    logic        preempt;

    int n_chk;
    int n_pass;
    int bad;

    io_bank_arbiter #(
        .N_REQ   (2),
        .WIDTH   (16),
        .MAX_HOLD(4)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .req_i    (req),
        .req_out_i(req_out),
        .req_oeb_i(req_oeb),
        .gnt_o    (gnt),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .busy_o   (busy),
        .preempt_o(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        req     = 2'b11;
        req_out = {16'h5A5A, 16'hA5A5};
        req_oeb = {16'hF0F0, 16'h00FF};

        // Reset holds pads released despite requests
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_oeb", 32'(io_oeb), 32'hFFFF);
        chk("rst_out", 32'(io_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single owner
        rst_n = 1'b1;
        req   = 2'b01;
        step();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_oeb_lat", 32'(io_oeb), 32'hFFFF);
        step();
        chk("single_out", 32'(io_out), 32'hA5A5);
        chk("single_oeb", 32'(io_oeb), 32'h00FF);
        req_out[15:0] = 16'h1234;
        step();
        chk("single_out2", 32'(io_out), 32'h1234);
        req = 2'b00;
        step();
        chk("drop_gnt", 32'(gnt), 32'h0);
        chk("drop_oeb", 32'(io_oeb), 32'hFFFF);
        chk("drop_out", 32'(io_out), 32'h0);
        step();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Reset ptr, then contention from IDLE
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 2'b11;
        step();
        chk("cont_gnt0", 32'(gnt), 32'h1);
        step();
        req = 2'b10;
        step();
        chk("cont_turn", 32'(gnt), 32'h0);
        chk("cont_turn_pre", 32'(preempt), 32'h0);
        step();
        chk("cont_gnt1", 32'(gnt), 32'h2);
        req = 2'b00;
        step();
        step();

        // Preemption: ptr now 0
        req = 2'b01;
        step();
        chk("pre_gnt0", 32'(gnt), 32'h1);
        req = 2'b11;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnt !== 2'b01 || preempt !== 1'b0) bad++;
        end
        chk("pre_hold0", 32'(bad), 32'h0);
        step();
        chk("pre_turn_gnt", 32'(gnt), 32'h0);
        chk("pre_pulse", 32'(preempt), 32'h1);
        step();
        chk("pre_gnt1", 32'(gnt), 32'h2);
        chk("pre_pulse_end", 32'(preempt), 32'h0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnt !== 2'b10 || preempt !== 1'b0) bad++;
        end
        chk("pre_hold1", 32'(bad), 32'h0);
        step();
        chk("pre2_pulse", 32'(preempt), 32'h1);
        step();
        chk("pre_regrant0", 32'(gnt), 32'h1);
        req = 2'b00;
        step();
        step();

        // Long uncontested hold
        req = 2'b01;
        step();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (gnt !== 2'b01 || preempt !== 1'b0) bad++;
        end
        chk("long_hold", 32'(bad), 32'h0);
        req = 2'b00;
        step();
        step();

        // Mid-grant reset
        req = 2'b10;
        step();
        chk("mr_gnt1", 32'(gnt), 32'h2);
        step();
        chk("mr_out1", 32'(io_out), 32'h5A5A);
        chk("mr_oeb1", 32'(io_oeb), 32'hF0F0);
        rst_n = 1'b0;
        step();
        chk("mr_gnt", 32'(gnt), 32'h0);
        chk("mr_oeb", 32'(io_oeb), 32'hFFFF);
        chk("mr_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        req   = 2'b11;
        step();
        chk("mr_ptr", 32'(gnt), 32'h1);

        // Release coinciding with timeout is not a preemption
        for (int i = 0; i < 4; i++) step();
        chk("co_still", 32'(gnt), 32'h1);
        req = 2'b10;
        step();
        chk("co_turn", 32'(gnt), 32'h0);
        chk("co_nopre", 32'(preempt), 32'h0);
        step();
        chk("co_gnt1", 32'(gnt), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/io_bank_arbiter.md
IO_BANK_ARBITER -- requirements
Module: io_bank_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters sharing the user IO bank.
REQ-002 SHALL have parameter WIDTH, default 16, pad count of the shared bank (io 0-7, 30-37 as packed).
REQ-003 SHALL have parameter MAX_HOLD, default 255, range 0-255, grant cycles before preemption; 0 disables preemption.
REQ-004 SHALL have one clock and a synchronous, active-low reset. Port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 wb_rst_ni  input  1  synchronous active-low reset, sampled on wb_clk_i.
REQ-006 req_i  input  N_REQ  level request per requester; held high for as long as ownership is wanted.
REQ-007 req_out_i  input  N_REQ*WIDTH  per-requester pad output values; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-008 req_oeb_i  input  N_REQ*WIDTH  per-requester pad output-enable-bar, same packing.
REQ-009 gnt_o  output  N_REQ  one-hot-or-zero grant, registered.
REQ-010 io_out  output  WIDTH  registered pad output bus.
REQ-011 io_oeb  output  WIDTH  registered pad oeb bus; 1 = pad is input.
REQ-012 busy_o  output  1  high while any requester holds the grant.
REQ-013 preempt_o  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 SHALL implement states IDLE, GRANT, TURN; encoding free.
REQ-015 IDLE: gnt_o=0; any req_i high -> GRANT to round-robin winner next cycle; none -> stay IDLE.
REQ-016 Round-robin: search starts at index ptr, ascending with wrap at N_REQ-1 -> 0; after granting k, ptr = (k+1) mod N_REQ.
REQ-017 GRANT, owner req high, no timeout: stay GRANT, gnt_o unchanged; io_out/io_oeb load owner's req_out_i/req_oeb_i slice every cycle (one-cycle latency).
REQ-018 GRANT, owner req low: -> TURN; io_oeb loads all-ones, io_out all-zeros on that edge.
REQ-019 Hold counter: 8-bit; cleared on entry to GRANT; increments each GRANT cycle, saturating at 255.
REQ-020 Preemption: MAX_HOLD!=0 and counter==MAX_HOLD and any non-owner req high -> TURN, preempt_o=1 for the following cycle only; if no other request, owner keeps grant indefinitely.
REQ-021 TURN: exactly one cycle; gnt_o=0, io_oeb all-ones, io_out all-zeros; then GRANT to RR winner if any req_i high, else IDLE.
REQ-022 No two requesters SHALL ever be granted in the same or adjacent cycles; every ownership change passes through TURN (bus-turnaround guard).
REQ-023 In IDLE and TURN, io_oeb SHALL be all-ones and io_out all-zeros.
REQ-024 busy_o = (state==GRANT), registered with gnt_o.
REQ-025 Simultaneous requests: RR order decides; a preempted owner that keeps req high is re-eligible but loses priority via ptr.
REQ-026 Owner drop and timeout in same cycle: treated as normal release; preempt_o stays 0.
REQ-027 req_i of non-owners during GRANT SHALL not affect outputs except via REQ-020.

Reset
REQ-028 wb_rst_ni low at a clock edge: state=IDLE, ptr=0, counter=0, gnt_o=0, busy_o=0, preempt_o=0, io_out=0, io_oeb=all-ones.
REQ-029 Reset asserted mid-GRANT SHALL release pads (io_oeb all-ones) on that same edge; reset has priority over all transitions.
REQ-030 First cycle after reset release SHALL behave as IDLE.

Verification (N_REQ=2, WIDTH=16, MAX_HOLD=4)
REQ-031 Reset: hold wb_rst_ni low 2 cycles with req_i=2'b11 -> gnt_o=0, io_oeb=16'hFFFF, io_out=0.
REQ-032 Single owner: req_i=2'b01, req_out slice0=16'hA5A5, oeb0=16'h00FF -> gnt_o=01 after 1 cycle, io_out=A5A5, io_oeb=00FF 1 cycle later; req drop -> TURN, io_oeb=FFFF.
REQ-033 Contention: req_i=2'b11 from IDLE, ptr=0 -> req0 granted; req0 drops -> 1 TURN cycle with gnt_o=0, then gnt_o=10.
REQ-034 Preemption: req0 held, req1 rises -> after 4 GRANT cycles, TURN, preempt_o pulses once, gnt_o=10; req0 re-granted only after req1 releases or times out.
REQ-035 No-contention hold: req0 held 300 cycles alone -> gnt_o=01 throughout, preempt_o never asserts.
REQ-036 Mid-grant reset: in GRANT to req1, wb_rst_ni low 1 cycle -> next edge gnt_o=0, io_oeb=FFFF; after release with req_i=2'b11, req0 granted (ptr reset).
